result_drain: RTL
=================

// Module: result_drain
// PURPOSE
//   Downstream stage of the systolic top. Snapshots the ROWS x ACC_W
//   result_flat vector when a capture pulse is raised, then streams it out
//   one row per handshake. Each row is requantized: rounding arithmetic right
//   shift, then signed saturation to OUT_W bits. Output uses a valid/ready
//   interface towards the next layer or the host buffer.
// PARAMETERS
//   ROWS     16  rows in result_flat, which is also the number of output beats
//   ACC_W    16  width of one signed accumulator lane
//   OUT_W     8  width of one signed requantized output
//   SHIFT_W   4  width of shift_amt (0..15)
//   ROW_W     4  width of out_row; must satisfy 2**ROW_W >= ROWS
// PORTS
//   clk          in   1            clock
//   rst          in   1            synchronous active-high reset
//   capture      in   1            pulse: result_flat is valid this cycle
//   result_flat  in   ROWS*ACC_W   signed lanes; row r = [r*ACC_W +: ACC_W]
//   shift_amt    in   SHIFT_W      requant shift, sampled with capture
//   clr_overrun  in   1            clears the sticky overrun flag
//   out_valid    out  1            out_data/out_row/out_last are valid
//   out_ready    in   1            consumer accepts the beat
//   out_data     out  OUT_W        requantized, saturated row value
//   out_row      out  ROW_W        index of the current row (0..ROWS-1)
//   out_last     out  1            high on the row ROWS-1 beat
//   busy         out  1            drain in progress (state DRAIN)
//   overrun      out  1            sticky: a capture was dropped
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Reset: state=IDLE; snapshot buffer, row index, latched shift and overrun
//     all clear to 0. Therefore out_valid=0, out_data=0, out_row=0,
//     out_last=0, busy=0, overrun=0.
//   - FSM states IDLE and DRAIN.
//       IDLE  + capture -> DRAIN. Load the buffer from result_flat, latch
//               shift_amt, set row=0.
//       DRAIN + handshake (out_valid & out_ready), row<ROWS-1 -> row+1.
//       DRAIN + handshake on row ROWS-1, no capture -> IDLE.
//       DRAIN + handshake on row ROWS-1, capture in the same cycle -> stay in
//               DRAIN, reload buffer and shift, set row=0. This gives
//               back-to-back streams with no bubble.
//       DRAIN + capture at any other time -> capture is ignored, buffer is
//               unchanged, overrun<=1.
//   - Latency: capture in cycle N gives out_valid=1 with row 0 in cycle N+1.
//     With out_ready held high, one beat per cycle; the last beat is in
//     cycle N+ROWS.
//   - out_valid = (state==DRAIN). While out_valid & !out_ready, out_data,
//     out_row and out_last hold stable.
//   - out_data is combinational from registered state only (buffer row mux
//     plus latched shift). It has no combinational path from inputs.
//   - Requant for lane value a and shift s:
//       s==0: v = a
//       s>0 : v = (a + (1<<(s-1))) >>> s, computed at ACC_W+1 bits so the
//             rounding add cannot wrap
//       out_data = v > 2**(OUT_W-1)-1 ? 2**(OUT_W-1)-1
//                : v < -2**(OUT_W-1)  ? -2**(OUT_W-1)
//                : v[OUT_W-1:0]
//   - overrun: set by a dropped capture; cleared by clr_overrun. If both occur
//     in the same cycle, set wins. Reset also clears it.
//   - Reset asserted mid-drain aborts the stream. out_valid drops the next
//     cycle and no partial state survives.
//   - out_ready may be high in IDLE; it has no effect there.
// TESTING
//   1. Reset, then capture with lane r = r*256 and shift=8, ready=1
//      -> 16 beats, out_data = 0..15, out_row = 0..15, out_last on beat 15,
//      busy falls after the last beat.
//   2. Saturation, shift=0: lanes 300, -300, 127, -128
//      -> out_data 127, -128, 127, -128.
//   3. Rounding, shift=2: lanes 5, 6, -6, -7
//      -> out_data 1, 2, -1, -2 (half rounds up).
//   4. Toggle out_ready 1,0,0,1,... -> each beat is held stable while ready=0,
//      no beat is lost or duplicated, total beats = 16.
//   5. Capture at row 5 of a drain -> overrun=1, stream unchanged. Capture on
//      the row-15 handshake -> new stream starts next cycle at row 0 with
//      no gap. Then clr_overrun -> overrun=0.
//   6. Assert rst at row 7 -> next cycle out_valid=0, busy=0, out_row=0. A
//      following capture starts a clean drain from row 0.

Source files
------------

// File: rtl/result_drain.sv
// result_drain: snapshots ROWS signed accumulators and streams them out one
// requantized (rounding shift + saturate) row per valid/ready handshake.
module result_drain #(
    parameter int ROWS    = 16,
    parameter int ACC_W   = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4,
    parameter int ROW_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [ROWS*ACC_W-1:0] result_flat,
    input  logic [SHIFT_W-1:0]    shift_amt,
    input  logic                  clr_overrun,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [ROW_W-1:0]      out_row,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun
);
    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_LO = -(ACC_W+1)'(2**(OUT_W-1));

    state_t                state_q, state_d;
    logic [ROWS*ACC_W-1:0] buf_q, buf_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic                  overrun_q, overrun_d;

    logic                  hs, at_last, drop;
    logic signed [ACC_W-1:0] lane;
    logic signed [ACC_W:0]   ext, rnd, sum, v;

    assign out_valid = state_q == DRAIN;
    assign busy      = out_valid;
    assign out_row   = row_q;
    assign overrun   = overrun_q;
    assign at_last   = row_q == ROW_W'(ROWS - 1);
    assign out_last  = out_valid && at_last;
    assign hs        = out_valid && out_ready;
    assign drop      = out_valid && capture && !(hs && at_last);

    // Widened by one bit so the rounding add cannot wrap.
    always_comb begin
        lane = buf_q[row_q*ACC_W +: ACC_W];
        ext  = {lane[ACC_W-1], lane};
        rnd  = shift_q == '0 ? '0 : (ACC_W+1)'(1) << (shift_q - SHIFT_W'(1));
        sum  = ext + rnd;
        v    = sum >>> shift_q;
        out_data = v > SAT_HI ? {1'b0, {(OUT_W-1){1'b1}}}
                 : v < SAT_LO ? {1'b1, {(OUT_W-1){1'b0}}}
                 : v[OUT_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        row_d     = row_q;
        shift_d   = shift_q;
        overrun_d = clr_overrun ? 1'b0 : overrun_q;
        if (drop)
            overrun_d = 1'b1;
        if (state_q == IDLE ? capture : (hs && at_last && capture)) begin
            state_d = DRAIN;
            buf_d   = result_flat;
            shift_d = shift_amt;
            row_d   = '0;
        end else if (hs) begin
            state_d = at_last ? IDLE : DRAIN;
            row_d   = at_last ? '0 : row_q + ROW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            row_q     <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            row_q     <= row_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
        end
    end
endmodule
